apb_reg_slave: RTL and testbench



---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_wait_counter.sv | 28 ++
 rtl/apb_reg_slave.sv | 168 ++++++++++++++++
 tb/tb_apb_reg_slave.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding (matches the requester FSMs),
// default register window base, register-index helpers and the decode record.
package apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b11;

    localparam logic [31:0] APB_BASE_ADDR = 32'hA000;

    // The two highest word indices of the window are the control registers.
    function automatic int idx_wait_cfg(input int num_regs);
        return num_regs - 2;
    endfunction

    function automatic int idx_xfer_cnt(input int num_regs);
        return num_regs - 1;
    endfunction

    // Each flag is one reason an access is rejected; any set flag makes it illegal.
    typedef struct packed {
        logic below_base;
        logic out_of_range;
        logic misaligned;
        logic ro_write;
    } decode_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter that paces wait states; zero marks the cycle in
// which the completer may assert PREADY.
module apb_wait_counter #(
    parameter int W = 4
) (
    input  logic         pclk,
    input  logic         preset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register completer: general RW registers, WAIT_CFG and a read-only
// transfer counter. Define APB_SLV_ERR_EN to drive pslverr_o on illegal accesses.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                N            = 32,
    parameter logic [N-1:0]      BASE_ADDR    = N'(APB_BASE_ADDR),
    parameter int                NUM_REGS     = 8,
    parameter int                WAIT_W       = 4,
    parameter logic [WAIT_W-1:0] WAIT_DEFAULT = '0
) (
    input  logic         pclk,
    input  logic         preset_n,
    input  logic         psel_i,
    input  logic         penable_i,
    input  logic [N-1:0] paddr_i,
    input  logic         pwrite_i,
    input  logic [N-1:0] pwdata_i,
    output logic [N-1:0] prdata_o,
    output logic         pready_o,
    output logic         pslverr_o
);

    localparam int IDX_W        = $clog2(NUM_REGS);
    localparam int NUM_GEN      = NUM_REGS - 2;
    localparam int IDX_WAIT_CFG = idx_wait_cfg(NUM_REGS);
    localparam int IDX_XFER_CNT = idx_xfer_cnt(NUM_REGS);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [N-3:0]      word_off;
    logic [IDX_W-1:0]  idx;
    decode_t           dec;
    logic              illegal;
    logic              wcnt_load;
    logic              wcnt_en;
    logic              wcnt_zero;
    logic              complete;
    logic              wr_en;
    logic [NUM_GEN-1:0] gen_we;
    logic [N-1:0]      gen_reg [NUM_GEN];
    logic [WAIT_W-1:0] wait_cfg_reg;
    logic [N-1:0]      xfer_cnt_reg;
    logic [N-1:0]      rd_word;

    // Address decode works on word offsets; BASE_ADDR is word aligned.
    assign word_off = paddr_i[N-1:2] - BASE_ADDR[N-1:2];
    assign idx      = word_off[IDX_W-1:0];

    always_comb begin
        dec              = '0;
        dec.below_base   = (paddr_i < BASE_ADDR);
        dec.out_of_range = (word_off[N-3:IDX_W] != '0);
        dec.misaligned   = (paddr_i[1:0] != 2'b00);
        dec.ro_write     = pwrite_i && (idx == IDX_W'(IDX_XFER_CNT));
    end

    assign illegal = |dec;

    // Wait count is (re)loaded on every entry into ACCESS, from SETUP or a skipped setup.
    assign wcnt_load = ((state_reg == ST_IDLE) && psel_i && penable_i) ||
                       ((state_reg == ST_SETUP) && psel_i);
    assign wcnt_en   = (state_reg == ST_ACCESS);

    apb_wait_counter #(
        .W (WAIT_W)
    ) u_wait_counter (
        .pclk     (pclk),
        .preset_n (preset_n),
        .load     (wcnt_load),
        .load_val (wait_cfg_reg),
        .en       (wcnt_en),
        .zero     (wcnt_zero)
    );

    assign pready_o = (state_reg == ST_ACCESS) && wcnt_zero;
    assign complete = pready_o && psel_i && penable_i;
    assign wr_en    = complete && pwrite_i && !illegal;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (psel_i) begin
                    state_next = penable_i ? ST_ACCESS : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = psel_i ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (complete || !psel_i || !penable_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    for (genvar gi = 0; gi < NUM_GEN; gi++) begin : g_gen_we
        assign gen_we[gi] = wr_en && (idx == IDX_W'(gi));
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_GEN; i++) begin
                gen_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_GEN; i++) begin
                if (gen_we[i]) begin
                    gen_reg[i] <= pwdata_i;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cfg_reg <= WAIT_DEFAULT;
        end else if (wr_en && (idx == IDX_W'(IDX_WAIT_CFG))) begin
            wait_cfg_reg <= pwdata_i[WAIT_W-1:0];
        end
    end

    // Errored transfers still count as completed transfers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            xfer_cnt_reg <= '0;
        end else if (complete) begin
            xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_GEN; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_word = gen_reg[i];
            end
        end
        if (idx == IDX_W'(IDX_WAIT_CFG)) begin
            rd_word = {{(N-WAIT_W){1'b0}}, wait_cfg_reg};
        end
        if (idx == IDX_W'(IDX_XFER_CNT)) begin
            rd_word = xfer_cnt_reg;
        end
    end

    assign prdata_o = (pready_o && !pwrite_i && !illegal) ? rd_word : '0;

`ifdef APB_SLV_ERR_EN
    assign pslverr_o = pready_o && illegal;
`else
    assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized bench for apb_reg_slave against a register-map model; a single
// negedge process compares every cycle's outputs with the model's expectation.
module tb_apb_reg_slave;

    localparam logic [31:0] BASE = 32'hA000;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_reg_slave #(
        .N            (32),
        .BASE_ADDR    (BASE),
        .NUM_REGS     (8),
        .WAIT_W       (4),
        .WAIT_DEFAULT (4'd0)
    ) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .psel_i    (psel),
        .penable_i (penable),
        .paddr_i   (paddr),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    // Model state: the register map as the master sees it.
    logic [31:0] m_gen [6];
    int          m_wait;
    logic [31:0] m_cnt;

    // Current transfer as seen by the compare process.
    bit          in_access;
    int          acc_cycle;
    int          exp_wait;
    int          low_cnt;
    logic [31:0] cur_addr;
    bit          cur_wr;
    logic [31:0] last_rd;
    logic        last_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_illegal(input logic [31:0] a, input bit wr);
        logic [31:0] off;
        if (a < BASE) return 1'b1;
        if ((a % 4) != 0) return 1'b1;
        off = (a - BASE) / 4;
        if (off >= 8) return 1'b1;
        if (wr && (off == 7)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 4;
        if (off < 6) return m_gen[off];
        if (off == 6) return 32'(m_wait);
        return m_cnt;
    endfunction

    task automatic m_complete(input logic [31:0] a, input bit wr, input logic [31:0] d);
        logic [31:0] off;
        if (wr && !m_illegal(a, wr)) begin
            off = (a - BASE) / 4;
            if (off < 6) m_gen[off] = d;
            else m_wait = int'(d % 16);
        end
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_gen[i] = '0;
        m_wait = 0;
        m_cnt  = '0;
    endtask

    always @(negedge pclk) begin
        logic [31:0] exp_rd;
        bit          exp_err;
        if (in_access) begin
            if (acc_cycle == exp_wait) begin
                check("pready_done", 32'(pready), 32'd1);
                exp_err = m_illegal(cur_addr, cur_wr);
                exp_rd  = (cur_wr || exp_err) ? 32'd0 : m_read(cur_addr);
                check("prdata", prdata, exp_rd);
`ifdef APB_SLV_ERR_EN
                check("pslverr", 32'(pslverr), 32'(exp_err));
`else
                check("pslverr", 32'(pslverr), 32'd0);
`endif
                last_rd  = prdata;
                last_err = pslverr;
            end else begin
                check("pready_wait", 32'(pready), 32'd0);
            end
            if (!pready) low_cnt++;
        end else begin
            check("idle_pready", 32'(pready), 32'd0);
            check("idle_pslverr", 32'(pslverr), 32'd0);
            check("idle_prdata", prdata, 32'd0);
        end
    end

    // Called at posedge+1 with the bus idle; returns at posedge+1 with psel low.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] d,
                        input bit skip, input int abort_at);
        bit drop_psel;
        drop_psel = 1'($urandom_range(0, 1));
        psel    = 1'b1;
        penable = skip;
        paddr   = a;
        pwrite  = wr;
        pwdata  = d;
        if (!skip) begin
            @(posedge pclk); #1;
            penable = 1'b1;
        end
        @(posedge pclk); #1;
        cur_addr  = a;
        cur_wr    = wr;
        exp_wait  = m_wait;
        acc_cycle = 0;
        low_cnt   = 0;
        in_access = 1'b1;
        for (int c = 0; c <= exp_wait; c++) begin
            if (c == abort_at) begin
                in_access = 1'b0;
                if (drop_psel) psel = 1'b0;
                else penable = 1'b0;
                @(posedge pclk); #1;
                psel    = 1'b0;
                penable = 1'b0;
                $display("[TB] abort %s addr=%h at access cycle %0d", wr ? "wr" : "rd", a, c);
                return;
            end
            @(posedge pclk);
            if (c == exp_wait) m_complete(a, wr, d);
            #1;
            acc_cycle = c + 1;
        end
        in_access = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        $display("[TB] %s addr=%h wdata=%h rdata=%h err=%0b waits=%0d skip=%0b",
                 wr ? "wr" : "rd", a, d, last_rd, last_err, low_cnt, skip);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          wr;
        int          sel;
        int          ab;

        preset_n  = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        paddr     = '0;
        pwrite    = 1'b0;
        pwdata    = '0;
        in_access = 1'b0;
        last_rd   = '0;
        last_err  = 1'b0;
        m_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        preset_n = 1'b1;
        @(posedge pclk); #1;

        // Preload, zero-wait read, counter value.
        xfer(BASE, 1'b1, 32'd5, 1'b0, -1);
        xfer(BASE, 1'b0, 32'd0, 1'b0, -1);
        check("lit_rd5", last_rd, 32'd5);
        check("lit_nowait", 32'(low_cnt), 32'd0);
        xfer(BASE + 32'h1C, 1'b0, 32'd0, 1'b0, -1);
        check("lit_cnt2", last_rd, 32'd2);

        // Three wait states.
        xfer(BASE + 32'h18, 1'b1, 32'd3, 1'b0, -1);
        xfer(BASE, 1'b0, 32'd0, 1'b0, -1);
        check("lit_wait3", 32'(low_cnt), 32'd3);
        check("lit_rd5_w", last_rd, 32'd5);

        // Read-modify-write loop.
        xfer(BASE, 1'b1, 32'd6, 1'b0, -1);
        xfer(BASE, 1'b0, 32'd0, 1'b0, -1);
        check("lit_rd6", last_rd, 32'd6);
        xfer(BASE + 32'h1C, 1'b0, 32'd0, 1'b0, -1);
        check("lit_cnt7", last_rd, 32'd7);

        // Illegal accesses.
        xfer(BASE + 32'h20, 1'b0, 32'd0, 1'b0, -1);
        check("lit_ill_rd", last_rd, 32'd0);
`ifdef APB_SLV_ERR_EN
        check("lit_ill_err", 32'(last_err), 32'd1);
`else
        check("lit_ill_err", 32'(last_err), 32'd0);
`endif
        xfer(BASE + 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, -1);
        xfer(BASE + 32'h1C, 1'b1, 32'h1234, 1'b0, -1);
        xfer(BASE, 1'b0, 32'd0, 1'b0, -1);
        check("lit_reg0_kept", last_rd, 32'd6);

        // Abort during a wait state, then skipped-setup read.
        xfer(BASE + 32'h4, 1'b1, 32'h55, 1'b0, 1);
        xfer(BASE + 32'h4, 1'b0, 32'd0, 1'b0, -1);
        check("lit_abort_reg1", last_rd, 32'd0);
        xfer(BASE, 1'b0, 32'd0, 1'b1, -1);
        check("lit_skip_rd", last_rd, 32'd6);

        // Counter wrap.
        xfer(BASE + 32'h18, 1'b1, 32'd0, 1'b0, -1);
        force dut.xfer_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_cnt_reg;
        m_cnt = 32'hFFFF_FFFF;
        xfer(BASE + 32'h1C, 1'b0, 32'd0, 1'b0, -1);
        check("lit_cnt_max", last_rd, 32'hFFFF_FFFF);
        xfer(BASE + 32'h1C, 1'b0, 32'd0, 1'b0, -1);
        check("lit_cnt_wrap", last_rd, 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            case (sel)
                6:       a = BASE + 32'(4 * $urandom_range(8, 12));
                7:       a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                8:       a = BASE - 32'(4 * $urandom_range(1, 4));
                9:       begin a = BASE + 32'h18; d = 32'($urandom_range(0, 20)); end
                default: a = BASE + 32'(4 * $urandom_range(0, 7));
            endcase
            ab = -1;
            if ((m_wait > 0) && ($urandom_range(0, 4) == 0)) ab = $urandom_range(0, m_wait - 1);
            xfer(a, wr, d, ($urandom_range(0, 3) == 0), ab);
        end

        // Reset in the middle of a waited write.
        xfer(BASE + 32'h18, 1'b1, 32'd3, 1'b0, -1);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = BASE;
        pwrite  = 1'b1;
        pwdata  = 32'hDEAD;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        #2;
        preset_n = 1'b0;
        #1;
        check("rstmid_pready", 32'(pready), 32'd0);
        check("rstmid_pslverr", 32'(pslverr), 32'd0);
        check("rstmid_prdata", prdata, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        m_reset();
        @(posedge pclk); #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        xfer(BASE + 32'h18, 1'b0, 32'd0, 1'b0, -1);
        check("lit_wait_default", last_rd, 32'd0);
        check("lit_wait_default_lat", 32'(low_cnt), 32'd0);
        xfer(BASE, 1'b0, 32'd0, 1'b0, -1);
        check("lit_reset_reg0", last_rd, 32'd0);
        xfer(BASE + 32'h1C, 1'b0, 32'd0, 1'b0, -1);
        check("lit_reset_cnt", last_rd, 32'd2);

        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
